// File: rtl/timer_counter_gen.sv
// Timer count engine: prescaled counter with free-run/auto-reload/one-shot modes and compare pulses.
// Optional capture port set is built when TIMER_CAPTURE_EN is defined.
module timer_counter_gen #(
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned NUM_CMP = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     timer_en,
    input  logic                     halt_en,
    input  logic                     div_en,
    input  logic [DIV_W-1:0]         div_val,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         reload_val,
    input  logic [CNT_W-1:0]         cnt_wdata,
    input  logic                     cnt_wr_en,
    input  logic                     cnt_clr,
    input  logic [NUM_CMP*CNT_W-1:0] cmp_val,
    output logic [CNT_W-1:0]         count,
    output logic                     cnt_update,
    output logic [NUM_CMP-1:0]       cmp_hit,
    output logic                     wrap_pulse,
    output logic                     oneshot_done
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic                     cap_trig,
    output logic [CNT_W-1:0]         cap_val,
    output logic                     cap_valid
`endif
);

    logic [DIV_W-1:0]   pre_cnt;
    logic               en_q;
    logic               tick;
    logic               clr;
    logic               tick_upd;
    logic               is_reload_mode;
    logic               at_reload;
    logic               wrap_ev;
    logic               done_clr;
    logic [CNT_W-1:0]   tick_nxt;
    logic [NUM_CMP-1:0] hit_d;

    always_comb begin
        tick = ~halt_en & timer_en & ~oneshot_done
             & (~div_en | (div_val == '0) | (pre_cnt == div_val));
        clr            = cnt_clr | (en_q & ~timer_en);
        // Compare and wrap events only count when the tick actually drives the update
        tick_upd       = tick & ~clr & ~cnt_wr_en;
        is_reload_mode = (mode == 2'd1) || (mode == 2'd2);
        at_reload      = (count == reload_val);
        done_clr       = cnt_clr | cnt_wr_en | ~timer_en | (mode != 2'd2);

        wrap_ev  = 1'b0;
        tick_nxt = count + CNT_W'(1);
        if (is_reload_mode && at_reload) begin
            wrap_ev  = 1'b1;
            tick_nxt = (mode == 2'd1) ? '0 : count;
        end else if (!is_reload_mode && (count == '1)) begin
            wrap_ev = 1'b1;
        end

        hit_d = '0;
        for (int i = 0; i < int'(NUM_CMP); i++) begin
            hit_d[i] = tick_upd & (tick_nxt == cmp_val[i*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt      <= '0;
            en_q         <= 1'b0;
            count        <= '0;
            cnt_update   <= 1'b0;
            cmp_hit      <= '0;
            wrap_pulse   <= 1'b0;
            oneshot_done <= 1'b0;
        end else if (!halt_en) begin
            en_q <= timer_en;

            if (!timer_en || !div_en || (pre_cnt == div_val)) begin
                pre_cnt <= '0;
            end else if (div_val != '0) begin
                pre_cnt <= pre_cnt + DIV_W'(1);
            end

            if (clr) begin
                count <= '0;
            end else if (cnt_wr_en) begin
                count <= cnt_wdata;
            end else if (tick) begin
                count <= tick_nxt;
            end

            cnt_update <= tick;
            wrap_pulse <= tick_upd & wrap_ev;
            cmp_hit    <= hit_d;

            if (done_clr) begin
                oneshot_done <= 1'b0;
            end else if (tick_upd && at_reload) begin
                oneshot_done <= 1'b1;
            end
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic cap_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_q     <= 1'b0;
            cap_val   <= '0;
            cap_valid <= 1'b0;
        end else if (!halt_en) begin
            cap_q     <= cap_trig;
            cap_valid <= cap_trig & ~cap_q;
            if (cap_trig && !cap_q) begin
                cap_val <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_timer_counter_gen.sv
// Randomized bench for timer_counter_gen: an 8-bit and a 64-bit instance share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_timer_counter_gen;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ten   = 1'b0;
    logic        halt  = 1'b0;
    logic        den   = 1'b0;
    logic [3:0]  dv    = '0;
    logic [1:0]  md    = '0;
    logic [63:0] rv    = '0;
    logic [63:0] wd    = '0;
    logic        wr    = 1'b0;
    logic        cclr  = 1'b0;
    logic [63:0] c0    = '0;
    logic [63:0] c1    = '0;

    logic [7:0]  cnt8;
    logic        upd8, wrap8, done8;
    logic [1:0]  hit8;
    logic [63:0] cnt64;
    logic        upd64, wrap64, done64;
    logic [1:0]  hit64;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    timer_counter_gen #(.CNT_W(8), .DIV_W(4), .NUM_CMP(2)) dut8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .timer_en(ten), .halt_en(halt), .div_en(den),
        .div_val(dv), .mode(md), .reload_val(rv[7:0]), .cnt_wdata(wd[7:0]), .cnt_wr_en(wr),
        .cnt_clr(cclr), .cmp_val({c1[7:0], c0[7:0]}), .count(cnt8), .cnt_update(upd8),
        .cmp_hit(hit8), .wrap_pulse(wrap8), .oneshot_done(done8)
    );

    timer_counter_gen #(.CNT_W(64), .DIV_W(4), .NUM_CMP(2)) dut64 (
        .sys_clk(clk), .sys_rst_n(rst_n), .timer_en(ten), .halt_en(halt), .div_en(den),
        .div_val(dv), .mode(md), .reload_val(rv), .cnt_wdata(wd), .cnt_wr_en(wr),
        .cnt_clr(cclr), .cmp_val({c1, c0}), .count(cnt64), .cnt_update(upd64),
        .cmp_hit(hit64), .wrap_pulse(wrap64), .oneshot_done(done64)
    );

    typedef struct {
        logic [63:0] cnt;
        int unsigned pre;
        bit          enq;
        bit          done;
        bit          upd;
        bit          wrap;
        bit   [1:0]  hit;
    } mst_t;

    mst_t m8, m64;

    function automatic mst_t zero_state();
        mst_t z;
        z.cnt = '0; z.pre = 0; z.enq = 0; z.done = 0; z.upd = 0; z.wrap = 0; z.hit = '0;
        return z;
    endfunction

    // One clock of the timer, from the behavioural rules; mask sets the counter width
    function automatic mst_t step(mst_t s, logic [63:0] mask);
        mst_t        n;
        logic [63:0] nx;
        bit          tick, clr, ev, tu, at_rl;
        n = s;
        if (halt) return n;
        n.enq = ten;
        if (!ten || !den || s.pre == int'(dv)) n.pre = 0;
        else if (dv != 0) n.pre = (s.pre + 1) % 16;
        tick  = ten && !s.done && (!den || dv == 0 || s.pre == int'(dv));
        clr   = cclr || (s.enq && !ten);
        tu    = tick && !clr && !wr;
        at_rl = (s.cnt == (rv & mask));
        ev    = 0;
        if (md == 2'd1 && at_rl) begin
            nx = '0; ev = 1;
        end else if (md == 2'd2 && at_rl) begin
            nx = s.cnt; ev = 1;
        end else begin
            nx = (s.cnt + 64'd1) & mask;
            ev = (md == 2'd0 || md == 2'd3) && (s.cnt == mask);
        end
        if (clr) n.cnt = '0;
        else if (wr) n.cnt = wd & mask;
        else if (tick) n.cnt = nx;
        n.upd    = tick;
        n.wrap   = tu && ev;
        n.hit[0] = tu && (nx == (c0 & mask));
        n.hit[1] = tu && (nx == (c1 & mask));
        if (cclr || wr || !ten || md != 2'd2) n.done = 0;
        else if (tu && at_rl) n.done = 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8  <= zero_state();
            m64 <= zero_state();
        end else begin
            m8  <= step(m8, 64'hFF);
            m64 <= step(m64, 64'hFFFF_FFFF_FFFF_FFFF);
        end
    end

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        chk("count8", 64'(cnt8), m8.cnt);
        chk("update8", 64'(upd8), 64'(m8.upd));
        chk("hit8", 64'(hit8), 64'(m8.hit));
        chk("wrap8", 64'(wrap8), 64'(m8.wrap));
        chk("done8", 64'(done8), 64'(m8.done));
        chk("count64", cnt64, m64.cnt);
        chk("update64", 64'(upd64), 64'(m64.upd));
        chk("hit64", 64'(hit64), 64'(m64.hit));
        chk("wrap64", 64'(wrap64), 64'(m64.wrap));
        chk("done64", 64'(done64), 64'(m64.done));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(2);
        chk("lit_reset_cnt", cnt64, 64'd0);
        rst_n = 1'b1;

        md = 2'd0; den = 1'b0; ten = 1'b1;
        cyc(10);
        chk("lit_free10", cnt64, 64'd10);
        chk("lit_upd", 64'(upd64), 64'd1);
        ten = 1'b0; cyc(1);
        chk("lit_fall_clr", cnt64, 64'd0);

        den = 1'b1; dv = 4'd4; ten = 1'b1;
        cyc(10);
        chk("lit_div5", cnt64, 64'd2);
        ten = 1'b0; den = 1'b0; cyc(1);

        md = 2'd1; rv = 64'd3; ten = 1'b1;
        cyc(6);
        chk("lit_reload", cnt64, 64'd2);
        ten = 1'b0; cyc(1);

        md = 2'd2; rv = 64'd5; ten = 1'b1;
        cyc(8);
        chk("lit_os_cnt", cnt64, 64'd5);
        chk("lit_os_done", 64'(done64), 64'd1);
        cclr = 1'b1; cyc(1); cclr = 1'b0;
        chk("lit_os_clr", cnt64, 64'd0);
        chk("lit_os_undone", 64'(done64), 64'd0);
        cyc(2);
        chk("lit_os_resume", cnt64, 64'd2);
        ten = 1'b0; cyc(1);

        md = 2'd0; c0 = 64'd2; c1 = 64'd7; ten = 1'b1;
        cyc(2);
        chk("lit_hit0", 64'(hit64), 64'd1);
        cyc(1);
        wr = 1'b1; wd = 64'd7; cyc(1); wr = 1'b0;
        chk("lit_load_cnt", cnt64, 64'd7);
        chk("lit_load_nohit", 64'(hit64), 64'd0);
        ten = 1'b0; cyc(1);

        den = 1'b1; dv = 4'd3; ten = 1'b1; wr = 1'b1; wd = 64'd20;
        cyc(1); wr = 1'b0;
        halt = 1'b1; cclr = 1'b1; ten = 1'b0;
        cyc(3);
        chk("lit_halt_cnt", cnt64, 64'd20);
        halt = 1'b0; cclr = 1'b0; ten = 1'b1;
        cyc(1);
        chk("lit_halt_resume", cnt64, 64'd20);
        cyc(8);

        wr = 1'b1; wd = 64'hFFFF_FFFF_FFFF_FFFD; den = 1'b0; md = 2'd0;
        cyc(1); wr = 1'b0;
        cyc(4);
        chk("lit_wrap64", cnt64, 64'd1);

        for (int i = 0; i < 3000; i++) begin
            ten  = ($urandom_range(0, 19) != 0);
            halt = ($urandom_range(0, 9) == 0);
            cclr = ($urandom_range(0, 39) == 0);
            wr   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) == 0) den = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) dv = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) rv = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) c0 = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) c1 = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else wd = 64'($urandom_range(0, 255));
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
